// File: rtl/fpu_line_unpacker.sv
// fpu_line_unpacker: gearbox from CCI-P read-response lines to FPU columns.
// Lines enter a small FIFO. Each line is byte-extracted as it loads into a
// byte shift stage, and the stage emits COL_WIDTH-byte columns over a
// valid/ready handshake. The final column of a frame is zero-padded and
// tagged last.
module fpu_line_unpacker #(
  parameter int LINE_WIDTH = 512,
  parameter int COL_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CHANNELS   = 4,
  parameter int AF_THRESH  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [LINE_WIDTH-1:0]       in_data,
  input  logic                        in_last,
  input  logic                        in_mode,
  input  logic [$clog2(CHANNELS)-1:0] in_chan_sel,
  output logic                        in_ready,
  output logic                        almost_full,
  output logic                        col_valid,
  input  logic                        col_ready,
  output logic [COL_WIDTH*8-1:0]      col_data,
  output logic                        col_last,
  output logic [15:0]                 col_count,
  output logic                        overflow_err
);

  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int N_CH       = LINE_BYTES / CHANNELS;
  localparam int CAP        = COL_WIDTH - 1 + LINE_BYTES;
  localparam int CAP_BITS   = CAP * 8;
  localparam int COL_BITS   = COL_WIDTH * 8;
  localparam int FILL_W     = $clog2(CAP + 1);
  localparam int SUM_W      = FILL_W + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int SEL_W      = $clog2(CHANNELS);

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Line FIFO storage (p0)
  logic [LINE_WIDTH-1:0] fifo_data_p0 [FIFO_DEPTH];
  logic                  fifo_last_p0 [FIFO_DEPTH];
  logic                  fifo_mode_p0 [FIFO_DEPTH];
  logic [SEL_W-1:0]      fifo_sel_p0  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;

  // Column stage (p1)
  logic [CAP_BITS-1:0]   stage_p1;
  logic [FILL_W-1:0]     fill_p1;
  logic                  last_pend_p1;
  logic                  clr_cnt_p1;

  logic                  wr_en;
  logic                  pop;
  logic                  hs;
  logic [LINE_WIDTH-1:0] head_data;
  logic [LINE_WIDTH-1:0] ext;
  logic [SUM_W-1:0]      ext_n;
  logic [SUM_W-1:0]      fill_ae;
  logic [CAP_BITS-1:0]   kept;
  logic [CAP_BITS-1:0]   stage_nxt;
  logic [FILL_W-1:0]     fill_nxt;

  assign in_ready    = (occ != OCC_W'(FIFO_DEPTH));
  assign almost_full = (occ >= OCC_W'(AF_THRESH));
  assign wr_en       = in_valid & in_ready;
  assign head_data   = fifo_data_p0[rd_ptr];

  assign col_valid = (fill_p1 >= FILL_W'(COL_WIDTH)) | (last_pend_p1 & (fill_p1 != '0));
  assign col_last  = last_pend_p1 & (fill_p1 <= FILL_W'(COL_WIDTH));
  assign hs        = col_valid & col_ready;

  // FIFO payload write; data path carries no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_data_p0[wr_ptr] <= in_data;
      fifo_last_p0[wr_ptr] <= in_last;
      fifo_mode_p0[wr_ptr] <= in_mode;
      fifo_sel_p0[wr_ptr]  <= in_chan_sel;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (in_valid & ~in_ready) overflow_err <= 1'b1;
    end
  end

  // Byte extraction of the FIFO head: raw line or one channel packed low
  always_comb begin
    ext   = '0;
    ext_n = SUM_W'(LINE_BYTES);
    if (fifo_mode_p0[rd_ptr]) begin
      for (int k = 0; k < N_CH; k++) begin
        ext[k*8 +: 8] = head_data[(int'(fifo_sel_p0[rd_ptr]) + k*CHANNELS)*8 +: 8];
      end
      ext_n = SUM_W'(N_CH);
    end else begin
      ext = head_data;
    end
  end

  // Output column: bytes at or above fill read as zero
  always_comb begin
    col_data = '0;
    for (int b = 0; b < COL_WIDTH; b++) begin
      if (FILL_W'(b) < fill_p1) col_data[b*8 +: 8] = stage_p1[b*8 +: 8];
    end
  end

  // Stage next state: drop the emitted column, then append a loaded line above what remains
  always_comb begin
    fill_ae = SUM_W'(fill_p1);
    kept    = stage_p1;
    if (hs) begin
      fill_ae = (fill_p1 >= FILL_W'(COL_WIDTH)) ? SUM_W'(fill_p1 - FILL_W'(COL_WIDTH)) : '0;
      kept    = stage_p1 >> COL_BITS;
    end
    for (int b = 0; b < CAP; b++) begin
      if (SUM_W'(b) >= fill_ae) kept[b*8 +: 8] = '0;
    end
    pop = (occ != '0) & ~last_pend_p1 & ((fill_ae + ext_n) <= SUM_W'(CAP));
    stage_nxt = kept;
    fill_nxt  = FILL_W'(fill_ae);
    if (pop) begin
      stage_nxt = kept | (CAP_BITS'(ext) << {fill_ae, 3'b000});
      fill_nxt  = FILL_W'(fill_ae + ext_n);
    end
  end

  // Stage byte register; data path carries no reset
  always_ff @(posedge clk) begin
    stage_p1 <= stage_nxt;
  end

  // Stage control: fill, frame-end tracking and the per-frame column counter
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_p1      <= '0;
      last_pend_p1 <= 1'b0;
      clr_cnt_p1   <= 1'b0;
      col_count    <= '0;
    end else begin
      fill_p1    <= fill_nxt;
      clr_cnt_p1 <= hs & col_last;
      if (hs & col_last)                  last_pend_p1 <= 1'b0;
      else if (pop & fifo_last_p0[rd_ptr]) last_pend_p1 <= 1'b1;
      if (clr_cnt_p1)  col_count <= '0;
      else if (hs)     col_count <= sat_inc(col_count);
    end
  end

endmodule

// File: tb/tb_fpu_line_unpacker.sv
// Scoreboard bench for fpu_line_unpacker: stimulus queues expected columns,
// a monitor pops and compares on every column handshake.
module tb_fpu_line_unpacker;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [511:0] in_data;
  logic         in_last;
  logic         in_mode;
  logic [1:0]   in_chan_sel;
  logic         in_ready;
  logic         almost_full;
  logic         col_valid;
  logic         col_ready;
  logic [79:0]  col_data;
  logic         col_last;
  logic [15:0]  col_count;
  logic         overflow_err;

  fpu_line_unpacker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .in_chan_sel(in_chan_sel),
    .in_ready(in_ready), .almost_full(almost_full), .col_valid(col_valid),
    .col_ready(col_ready), .col_data(col_data), .col_last(col_last),
    .col_count(col_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] data;
    logic        last;
    logic [15:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] mk_line(input int base);
    logic [511:0] l;
    for (int j = 0; j < 64; j++) l[j*8 +: 8] = 8'(base + j);
    return l;
  endfunction

  task automatic add_raw(input int base);
    for (int j = 0; j < 64; j++) fb.push_back(8'(base + j));
  endtask

  task automatic add_chan(input int base, input int sel);
    for (int k = 0; k < 16; k++) fb.push_back(8'(base + sel + 4*k));
  endtask

  // Chop the frame byte stream into 10-byte columns, zero-pad the tail.
  task automatic close_frame();
    exp_t e;
    int   nb;
    nb = fb.size();
    for (int i = 0; i < nb; i += 10) begin
      e.data = '0;
      for (int b = 0; b < 10; b++)
        if (i + b < nb) e.data[b*8 +: 8] = fb[i+b];
      e.last = (i + 10 >= nb);
      e.cnt  = 16'(i / 10);
      sb.push_back(e);
    end
    fb.delete();
  endtask

  task automatic send_line(input logic [511:0] d, input logic last,
                           input logic mode, input logic [1:0] sel);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!in_ready && n < 500);
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_last = last; in_mode = mode; in_chan_sel = sel;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("drain_empty", 32'(sb.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted column against the scoreboard head,
  // and follow a last column with col_count = frame length, then 0.
  int          cnt_stage = 0;
  logic [15:0] cnt_exp;
  always @(negedge clk) begin
    if (rst) begin
      cnt_stage = 0;
    end else begin
      if (cnt_stage == 1) begin
        chk("col_count_final", col_count, cnt_exp);
        cnt_stage = 2;
      end else if (cnt_stage == 2) begin
        chk("col_count_clear", col_count, 0);
        cnt_stage = 0;
      end
      if (col_valid && col_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_col", col_data, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("col_data", col_data, e.data);
          chk("col_last", col_last, e.last);
          chk("col_count", col_count, e.cnt);
          if (e.last) begin
            cnt_exp   = e.cnt + 16'd1;
            cnt_stage = 1;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_mode = 1'b0; in_chan_sel = 2'd0; col_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_col_valid", col_valid, 0);
    chk("rst_col_last", col_last, 0);
    chk("rst_col_data", col_data, 0);
    chk("rst_col_count", col_count, 0);
    chk("rst_overflow", overflow_err, 0);
    rst = 1'b0;

    // One raw line 0..63, last: 7 columns, two-cycle latency
    col_ready = 1'b1;
    add_raw(0); close_frame();
    send_line(mk_line(0), 1'b1, 1'b0, 2'd0);
    chk("latency_cycle1", col_valid, 0);
    @(posedge clk); #1;
    chk("latency_cycle2", col_valid, 1);
    drain();

    // Two raw lines 0..127: column 6 spans the line boundary
    add_raw(0); add_raw(64); close_frame();
    send_line(mk_line(0),  1'b0, 1'b0, 2'd0);
    send_line(mk_line(64), 1'b1, 1'b0, 2'd0);
    drain();

    // Channel extract, chan_sel=2: bytes 2,6,..,62
    add_chan(0, 2); close_frame();
    send_line(mk_line(0), 1'b1, 1'b1, 2'd2);
    drain();

    // Channel extract over two lines, chan_sel=3
    add_chan(10, 3); add_chan(90, 3); close_frame();
    send_line(mk_line(10), 1'b0, 1'b1, 2'd3);
    send_line(mk_line(90), 1'b1, 1'b1, 2'd3);
    drain();

    // Backpressure: one line in stage, four in FIFO
    col_ready = 1'b0;
    for (int i = 0; i < 6; i++) add_raw(i * 64);
    close_frame();
    send_line(mk_line(0),   1'b0, 1'b0, 2'd0);
    send_line(mk_line(64),  1'b0, 1'b0, 2'd0);
    send_line(mk_line(128), 1'b0, 1'b0, 2'd0);
    chk("af_occ2", almost_full, 0);
    send_line(mk_line(192), 1'b0, 1'b0, 2'd0);
    chk("af_occ3", almost_full, 1);
    chk("in_ready_occ3", in_ready, 1);
    send_line(mk_line(256), 1'b0, 1'b0, 2'd0);
    chk("in_ready_full", in_ready, 0);
    repeat (9) @(posedge clk);
    #1;
    chk("stall_col_valid", col_valid, 1);
    chk("stall_overflow", overflow_err, 0);
    col_ready = 1'b1;
    send_line(mk_line(320), 1'b1, 1'b0, 2'd0);
    drain();

    // Overflow: a line pushed into a full FIFO is dropped
    col_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      add_raw(7 * i + 1);
      send_line(mk_line(7 * i + 1), 1'b0, 1'b0, 2'd0);
    end
    @(posedge clk); #1;
    chk("ovf_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = mk_line(200); in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("ovf_set", overflow_err, 1);
    add_raw(33); close_frame();
    col_ready = 1'b1;
    send_line(mk_line(33), 1'b1, 1'b0, 2'd0);
    drain();
    chk("ovf_sticky", overflow_err, 1);

    // Mid-frame reset with a column on offer, then a fresh frame
    col_ready = 1'b0;
    send_line(mk_line(50), 1'b0, 1'b0, 2'd0);
    send_line(mk_line(51), 1'b0, 1'b0, 2'd0);
    begin
      int n;
      n = 0;
      while (!col_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
    end
    chk("pre_rst_col_valid", col_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_col_valid", col_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_overflow", overflow_err, 0);
    rst = 1'b0;
    col_ready = 1'b1;
    add_raw(100); close_frame();
    send_line(mk_line(100), 1'b1, 1'b0, 2'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
